// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_e        : loader FSM states
//   BYTES_PER_WORD : stream bytes packed into one 32-bit instruction
//   CORE_HOLD      : core_rst level that keeps the datapath in reset
package inst_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam int   BYTES_PER_WORD = 4;
    localparam logic CORE_HOLD      = 1'b1;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word assembler with running XOR.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous clear of lane index, word and XOR accumulator
//   push          : accept din this cycle
//   din[7:0]      : stream byte
//   word_full     : this push completes a word (combinational)
//   word_next     : word contents including this cycle's push (combinational)
//   xor_acc[7:0]  : XOR of every byte pushed since the last clear
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic        word_full,
    output logic [31:0] word_next,
    output logic [7:0]  xor_acc
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;

    // Each lane takes the incoming byte only when it is the current slot,
    // so the completed word is visible in word_next on the fourth push.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign word_next[8*gi +: 8] = (push && (byte_idx_q == LANE)) ? din
                                                                          : word_q[8*gi +: 8];
        end
    endgenerate

    assign word_full = push && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign xor_acc   = xor_q;

    always_comb begin
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        xor_d      = xor_q;
        if (clear) begin
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
            xor_d      = 8'd0;
        end else if (push) begin
            byte_idx_d = byte_idx_q + 2'd1;   // wraps mod 4
            word_d     = word_next;
            xor_d      = xor_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            xor_q      <= 8'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader in front of the instruction memory.
// Receives a byte stream (valid/ready), packs it little-endian into 32-bit
// words, writes them to consecutive word addresses, then checks a trailing
// XOR checksum byte. The datapath is held in reset until the checksum passes.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, len               : load request pulse and program length (words)
//   byte_valid/data/ready    : byte stream handshake
//   im_we/im_addr/im_wdata   : instruction memory write port (byte address)
//   core_rst                 : datapath reset, 1 = hold
//   busy, done, err          : status (load active, checksum pass pulse, sticky error)
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [ADDR_W:0] len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          im_we,
    output logic [31:0]   im_addr,
    output logic [31:0]   im_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [ADDR_W:0] MAX_LEN = MAX_WORDS[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE = 1;
    localparam logic [ADDR_W:0] CNT_ZERO = '0;

    state_e          state_q, state_d;
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [31:0]     im_addr_q, im_addr_d;
    logic [31:0]     im_wdata_q, im_wdata_d;
    logic            byte_ready_q, byte_ready_d;
    logic            im_we_q, im_we_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            pk_clear;
    logic            pk_push;
    logic            pk_word_full;
    logic [31:0]     pk_word_next;
    logic [7:0]      pk_xor_acc;
    logic            xfer;
    logic [ADDR_W:0] word_cnt_inc;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .push      (pk_push),
        .din       (byte_data),
        .word_full (pk_word_full),
        .word_next (pk_word_next),
        .xor_acc   (pk_xor_acc)
    );

    // byte_ready is registered, so the handshake uses the value the source sees.
    assign xfer         = byte_valid && byte_ready_q;
    assign word_cnt_inc = word_cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        done_d     = 1'b0;
        pk_clear   = 1'b0;
        pk_push    = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    pk_clear   = 1'b1;
                    word_cnt_d = CNT_ZERO;
                    len_d      = len;
                    if (len > MAX_LEN) begin
                        state_d = ST_ERROR;
                    end else if (len == CNT_ZERO) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (xfer) begin
                    pk_push = 1'b1;
                    if (pk_word_full) begin
                        state_d    = ST_WRITE;
                        // Address and data are latched now so they are
                        // presented in the same cycle as im_we.
                        im_addr_d  = {{(32-ADDR_W-3){1'b0}}, word_cnt_q, 2'b00};
                        im_wdata_d = pk_word_next;
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                state_d    = (word_cnt_inc == len_q) ? ST_CHECK : ST_RECV;
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (byte_data == pk_xor_acc) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Level outputs are derived from the next state so that the
        // registered copies line up with the state register.
        byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
        im_we_d      = (state_d == ST_WRITE);
        busy_d       = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
        core_rst_d   = (state_d == ST_RUN) ? ~CORE_HOLD : CORE_HOLD;
        // ERROR is left only through an accepted start, which clears err.
        err_d        = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            len_q        <= '0;
            im_addr_q    <= 32'd0;
            im_wdata_q   <= 32'd0;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            core_rst_q   <= CORE_HOLD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            byte_ready_q <= byte_ready_d;
            im_we_q      <= im_we_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: reset, single- and multi-word loads,
// back-pressure, bad checksum, length boundaries, restart and mid-load reset.
module tb_inst_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    inst_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte and return right after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        step();
        byte_valid = 1'b0;
        $display("byte 0x%02h transferred", b);
    endtask

    task automatic pulse_start(input logic [8:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        $display("start len=%0d", l);
    endtask

    logic [31:0] exp_words [3];

    initial begin
        exp_words[0] = 32'h14131211;
        exp_words[1] = 32'h18171615;
        exp_words[2] = 32'h1C1B1A19;

        rst = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
        step();
        step();

        // ---- asynchronous reset, checked mid-cycle ----
        #3 rst = 1'b0;
        #1;
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_im_addr", im_addr, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        step();
        #2 rst = 1'b1;
        step();

        // ---- one-word load; a byte offered with start is not consumed ----
        byte_valid = 1'b1;
        byte_data  = 8'h93;
        pulse_start(9'd1);
        check("w1_recv_ready", {31'd0, byte_ready}, 32'd1);
        check("w1_recv_busy", {31'd0, busy}, 32'd1);
        check("w1_recv_core_rst", {31'd0, core_rst}, 32'd1);
        send_byte(8'h93);
        send_byte(8'h02);
        send_byte(8'h50);
        send_byte(8'h00);
        check("w1_we", {31'd0, im_we}, 32'd1);
        check("w1_addr", im_addr, 32'h0);
        check("w1_wdata", im_wdata, 32'h00500293);
        check("w1_write_ready", {31'd0, byte_ready}, 32'd0);
        // 0x93 ^ 0x02 ^ 0x50 ^ 0x00 = 0xC1
        send_byte(8'hC1);
        check("w1_done", {31'd0, done}, 32'd1);
        check("w1_core_rst", {31'd0, core_rst}, 32'd0);
        check("w1_busy", {31'd0, busy}, 32'd0);
        check("w1_err", {31'd0, err}, 32'd0);
        step();
        check("w1_done_pulse", {31'd0, done}, 32'd0);
        check("w1_run_core_rst", {31'd0, core_rst}, 32'd0);

        // ---- restart from RUN: three words, valid dropped on alternate cycles ----
        pulse_start(9'd3);
        check("w3_restart_core_rst", {31'd0, core_rst}, 32'd1);
        check("w3_restart_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            byte_valid = 1'b0;
            if (i == 5) begin
                start = 1'b1;       // ignored while receiving
                len   = 9'd1;
            end
            step();
            start = 1'b0;
            if (i == 5) check("w3_start_ignored_busy", {31'd0, busy}, 32'd1);
            if (i == 4 || i == 8) check("w3_we_one_cycle", {31'd0, im_we}, 32'd0);
            send_byte(8'h11 + 8'(i));
            if (i % 4 == 3) begin
                check("w3_we", {31'd0, im_we}, 32'd1);
                check("w3_addr", im_addr, 32'(4 * (i / 4)));
                check("w3_wdata", im_wdata, exp_words[i / 4]);
                check("w3_write_ready", {31'd0, byte_ready}, 32'd0);
            end
        end
        byte_valid = 1'b0;
        step();
        check("w3_check_we", {31'd0, im_we}, 32'd0);
        // XOR of 0x11..0x1C = 0x0C
        send_byte(8'h0C);
        check("w3_done", {31'd0, done}, 32'd1);
        check("w3_core_rst", {31'd0, core_rst}, 32'd0);

        // ---- bad checksum ----
        pulse_start(9'd1);
        send_byte(8'h93);
        send_byte(8'h02);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h00);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_core_rst", {31'd0, core_rst}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_ready", {31'd0, byte_ready}, 32'd0);
        step();
        step();
        check("bad_err_sticky", {31'd0, err}, 32'd1);

        // ---- len=0 from ERROR: clears err, checksum only ----
        pulse_start(9'd0);
        check("len0_err_cleared", {31'd0, err}, 32'd0);
        check("len0_busy", {31'd0, busy}, 32'd1);
        check("len0_ready", {31'd0, byte_ready}, 32'd1);
        check("len0_no_we", {31'd0, im_we}, 32'd0);
        send_byte(8'h00);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_no_we_after", {31'd0, im_we}, 32'd0);

        // ---- len=MAX_WORDS+1 ----
        pulse_start(9'd257);
        check("maxp1_err", {31'd0, err}, 32'd1);
        check("maxp1_ready", {31'd0, byte_ready}, 32'd0);
        check("maxp1_busy", {31'd0, busy}, 32'd0);
        step();
        check("maxp1_ready_later", {31'd0, byte_ready}, 32'd0);

        // ---- reset in the middle of a load ----
        pulse_start(9'd2);
        check("mid_err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("mid_wdata", im_wdata, 32'hDDCCBBAA);
        send_byte(8'h01);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        check("mid_rst_we", {31'd0, im_we}, 32'd0);
        step();
        #2 rst = 1'b1;
        step();
        step();
        check("post_rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
